// File: rtl/sync_frame_rx.sv
// Serial frame receiver: shifts bits into a PKT_W window, hunts for a sync field and
// captures matching frames onto a valid/ack handshake. Optional macro: SYNC_TOL_EN.
module sync_frame_rx #(
  parameter int unsigned       PKT_W    = 64,
  parameter int unsigned       SYNC_W   = 8,
  parameter int unsigned       SYNC_LSB = 38,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hFF,
  parameter bit                SYNC_REV = 1'b1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             pkt_rst,
  input  logic             pkt_ack,
  output logic [PKT_W-1:0] dout,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_valid,
  output logic             pkt_overrun,
  output logic [CNT_W-1:0] pkt_count,
  output logic             hunting
`ifdef SYNC_TOL_EN
  ,
  output logic             sync_err
`endif
);

  localparam int unsigned FILL_W = $clog2(PKT_W + 1);

  typedef enum logic {FILL, HUNT} state_t;

  state_t            state_q, state_d;
  logic [PKT_W-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SYNC_W-1:0] field, diff;
  logic              match, capture, accept;
`ifdef SYNC_TOL_EN
  logic              match_err;
`endif

  // Sync field extraction, optionally bit-reversed, and pattern comparison
  always_comb begin
    field = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      if (SYNC_REV) field[i] = window_q[SYNC_LSB + SYNC_W - 1 - i];
      else          field[i] = window_q[SYNC_LSB + i];
    end
    diff = field ^ SYNC_PAT;
`ifdef SYNC_TOL_EN
    match     = ($countones(diff) <= 1);
    match_err = ($countones(diff) == 1);
`else
    match     = (diff == '0);
`endif
  end

  assign capture = (state_q == HUNT) && match && !pkt_rst;
  assign accept  = capture && (!pkt_valid || pkt_ack);

  // Window, fill count and FILL/HUNT next state
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    state_d  = state_q;
    if (pkt_rst) begin
      window_d = '0;
      fill_d   = '0;
    end else begin
      if (en) begin
        window_d = {window_q[PKT_W-2:0], din};
        if (fill_q != FILL_W'(PKT_W)) fill_d = fill_q + FILL_W'(1);
      end
      // a capture restarts the fill so a frame is never detected twice
      if (capture) fill_d = '0;
    end
    case (state_q)
      FILL:    if (fill_d == FILL_W'(PKT_W)) state_d = HUNT;
      HUNT:    if (capture || pkt_rst)       state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

  // Holding register, handshake, overrun flag and frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      pkt_overrun <= 1'b0;
      pkt_count   <= '0;
`ifdef SYNC_TOL_EN
      sync_err    <= 1'b0;
`endif
    end else begin
      if (pkt_rst)                 pkt_overrun <= 1'b0;
      else if (capture && !accept) pkt_overrun <= 1'b1;
      if (accept) begin
        pkt_data  <= window_q;
        pkt_valid <= 1'b1;
        pkt_count <= pkt_count + CNT_W'(1);
`ifdef SYNC_TOL_EN
        sync_err  <= match_err;
`endif
      end else if (pkt_ack) begin
        pkt_valid <= 1'b0;
      end
    end
  end

  assign dout    = window_q;
  assign hunting = (state_q == HUNT);

endmodule

// File: tb/tb_sync_frame_rx.sv
// Directed bench for sync_frame_rx (default geometry, CNT_W=2 to reach counter wrap).
module tb_sync_frame_rx;

  localparam logic [63:0] FRAME_A = 64'h0000_3FC0_0000_0000;
  localparam logic [63:0] FRAME_B = 64'h8000_3FC0_0000_0005;
  localparam logic [63:0] FRAME_C = 64'h0000_3F80_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, din = 1'b0, pkt_rst = 1'b0, pkt_ack = 1'b0;
  logic [63:0] dout, pkt_data;
  logic        pkt_valid, pkt_overrun, hunting;
  logic [1:0]  pkt_count;
`ifdef SYNC_TOL_EN
  logic        sync_err;
`endif

  int total = 0;
  int bad   = 0;

  sync_frame_rx #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .pkt_rst(pkt_rst), .pkt_ack(pkt_ack),
    .dout(dout), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_overrun(pkt_overrun),
    .pkt_count(pkt_count), .hunting(hunting)
`ifdef SYNC_TOL_EN
    , .sync_err(sync_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; din = 1'b0; pkt_rst = 1'b0; pkt_ack = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic shift_frame(input logic [63:0] f, input int gap);
    for (int i = 63; i >= 0; i--) begin
      en = 1'b1; din = f[i];
      tick();
      en = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    en = 1'b0; din = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    shift_frame(FRAME_A, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; din = 1'b1; tick();
    end
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if (dout !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pkt_valid); end
    total++; if (pkt_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", pkt_data); end
    total++; if (pkt_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pkt_count); end
    total++; if (hunting !== 1'b0 || pkt_overrun !== 1'b0) begin
      bad++; $display("FAIL reset_flags got hunt=%b ovr=%b exp=0", hunting, pkt_overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 63; i++) begin
      en = 1'b1; din = 1'b0; tick();
    end
    total++; if (hunting !== 1'b0) begin bad++; $display("FAIL hunt_after63 got=%b exp=0", hunting); end
    tick();
    en = 1'b0;
    total++; if (hunting !== 1'b1) begin bad++; $display("FAIL hunt_after64 got=%b exp=1", hunting); end
  endtask

  task automatic test_capture();
    do_reset();
    shift_frame(FRAME_A, 0);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL cap_latency got=%b exp=0", pkt_valid); end
    total++; if (dout !== FRAME_A) begin bad++; $display("FAIL cap_dout got=%h exp=%h", dout, FRAME_A); end
    tick();
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%b exp=1", pkt_valid); end
    total++; if (pkt_data !== 64'h0000_3FC0_0000_0000) begin
      bad++; $display("FAIL cap_data got=%h exp=%h", pkt_data, 64'h0000_3FC0_0000_0000);
    end
    total++; if (pkt_count !== 2'd1) begin bad++; $display("FAIL cap_count got=%0d exp=1", pkt_count); end
    total++; if (hunting !== 1'b0) begin bad++; $display("FAIL cap_refill got=%b exp=0", hunting); end
`ifdef SYNC_TOL_EN
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL cap_syncerr got=%b exp=0", sync_err); end
`endif
  endtask

  task automatic test_overrun();
    do_reset();
    shift_frame(FRAME_A, 0);
    tick();
    shift_frame(FRAME_B, 0);
    tick();
    total++; if (pkt_data !== FRAME_A) begin bad++; $display("FAIL ovr_data got=%h exp=%h", pkt_data, FRAME_A); end
    total++; if (pkt_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", pkt_overrun); end
    total++; if (pkt_count !== 2'd1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", pkt_count); end
    pkt_rst = 1'b1;
    tick();
    pkt_rst = 1'b0;
    total++; if (pkt_overrun !== 1'b0) begin bad++; $display("FAIL pktrst_ovr got=%b exp=0", pkt_overrun); end
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL pktrst_valid got=%b exp=1", pkt_valid); end
    total++; if (dout !== 64'h0 || hunting !== 1'b0) begin
      bad++; $display("FAIL pktrst_window got dout=%h hunt=%b exp=0/0", dout, hunting);
    end
    total++; if (pkt_data !== FRAME_A) begin bad++; $display("FAIL pktrst_data got=%h exp=%h", pkt_data, FRAME_A); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    shift_frame(FRAME_A, 0);
    tick();
    shift_frame(FRAME_B, 0);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", pkt_valid); end
    total++; if (pkt_data !== FRAME_B) begin bad++; $display("FAIL b2b_data got=%h exp=%h", pkt_data, FRAME_B); end
    total++; if (pkt_count !== 2'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", pkt_count); end
    total++; if (pkt_overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b exp=0", pkt_overrun); end
    pkt_ack = 1'b1;
    tick();
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b exp=0", pkt_valid); end
    tick();
    pkt_ack = 1'b0;
    total++; if (pkt_valid !== 1'b0 || pkt_count !== 2'd2) begin
      bad++; $display("FAIL ack_idle got valid=%b cnt=%0d exp=0/2", pkt_valid, pkt_count);
    end
  endtask

  task automatic test_no_redetect();
    do_reset();
    shift_frame(FRAME_A, 1);
    for (int i = 0; i < 10; i++) tick();
    total++; if (pkt_count !== 2'd1 || pkt_valid !== 1'b1) begin
      bad++; $display("FAIL gap_single got cnt=%0d valid=%b exp=1/1", pkt_count, pkt_valid);
    end
    total++; if (pkt_data !== FRAME_A) begin bad++; $display("FAIL gap_data got=%h exp=%h", pkt_data, FRAME_A); end
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (pkt_valid !== 1'b0 || pkt_count !== 2'd1) begin
      bad++; $display("FAIL redetect got valid=%b cnt=%0d exp=0/1", pkt_valid, pkt_count);
    end
    do_reset();
    shift_frame(FRAME_C, 0);
    for (int i = 0; i < 3; i++) tick();
`ifdef SYNC_TOL_EN
    total++; if (pkt_valid !== 1'b1 || pkt_data !== FRAME_C) begin
      bad++; $display("FAIL tol_capture got valid=%b data=%h exp=1/%h", pkt_valid, pkt_data, FRAME_C);
    end
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL tol_syncerr got=%b exp=1", sync_err); end
`else
    total++; if (pkt_valid !== 1'b0 || pkt_count !== 2'd0) begin
      bad++; $display("FAIL fe_nomatch got valid=%b cnt=%0d exp=0/0", pkt_valid, pkt_count);
    end
    total++; if (hunting !== 1'b1) begin bad++; $display("FAIL fe_hunting got=%b exp=1", hunting); end
`endif
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      shift_frame(FRAME_A, 0);
      tick();
      total++; if (pkt_count !== exp_seq[k]) begin
        bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", k, pkt_count, exp_seq[k]);
      end
      pkt_ack = 1'b1;
      tick();
      pkt_ack = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_capture();
    test_overrun();
    test_back_to_back();
    test_no_redetect();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
